// File: rtl/qdr_resp_pkg.sv
// Shared widths, FSM states and LFSR constants for the QDR BlockRAM responder.
package qdr_resp_pkg;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned LANE_W = 9;
  localparam int unsigned NLANES = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_BEAT2 = 2'd2
  } qdr_state_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/qdr_resp_ram.sv
// Simple dual-port BlockRAM, per-lane write enables, 1-cycle synchronous read.
module qdr_resp_ram
  import qdr_resp_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic [NLANES-1:0] we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (we[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/qdr_bram_responder.sv
// QDR user-port responder backed by on-chip RAM; fixed-latency 2-beat bursts.
// Optional random ack stalls when QDR_RESP_STALL_EN is defined.
module qdr_bram_responder
  import qdr_resp_pkg::*;
#(
  parameter int QDR_LATENCY = 10,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic              qdr_clk,
  input  logic              qdr_rst,
  input  logic              qdr_req,
  output logic              qdr_ack,
  input  logic [31:0]       qdr_addr,
  input  logic              qdr_r,
  input  logic              qdr_w,
  input  logic [DATA_W-1:0] qdr_d,
  input  logic [NLANES-1:0] qdr_be,
  output logic [DATA_W-1:0] qdr_q,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              proto_err
);
  localparam int unsigned PIPE_D = QDR_LATENCY - 1;

  qdr_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic op_rd_q, op_wr_q;
  logic is_rd, is_wr, stall;
  logic [NLANES-1:0] ram_we;
  logic [ADDR_WIDTH:0] ram_addr;
  logic ram_re, rd_vld_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] q_pipe [PIPE_D];
  logic unused_addr_hi;

  assign unused_addr_hi = ^qdr_addr[31:ADDR_WIDTH];
  // r and w together are treated as a write
  assign is_wr = qdr_w;
  assign is_rd = qdr_r & ~qdr_w;

`ifdef QDR_RESP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ram_we   = '0;
    ram_re   = 1'b0;
    ram_addr = {qdr_addr[ADDR_WIDTH-1:0], 1'b0};
    case (state_q)
      ST_IDLE: if (qdr_req && !stall) state_d = ST_ACK;
      ST_ACK: begin
        state_d = ST_BEAT2;
        if (is_wr) ram_we = qdr_be;
        ram_re = is_rd;
      end
      ST_BEAT2: begin
        state_d  = ST_IDLE;
        ram_addr = {addr_q, 1'b1};
        if (op_wr_q) ram_we = qdr_be;
        ram_re = op_rd_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      state_q   <= ST_IDLE;
      qdr_ack   <= 1'b0;
      addr_q    <= '0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      qdr_ack  <= (state_d == ST_ACK);
      rd_vld_q <= ram_re;
      if (state_q == ST_ACK) begin
        addr_q  <= qdr_addr[ADDR_WIDTH-1:0];
        op_rd_q <= is_rd;
        op_wr_q <= is_wr;
        if (is_rd) rd_count <= rd_count + CNT_W'(1);
        if (is_wr) wr_count <= wr_count + CNT_W'(1);
        if ((qdr_r && qdr_w) || !qdr_req) proto_err <= 1'b1;
      end
    end
  end

  // RAM output lands one cycle after ack; PIPE_D more stages put beat 0 at ack+QDR_LATENCY
  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      for (int unsigned i = 0; i < PIPE_D; i++) q_pipe[i] <= '0;
    end else begin
      q_pipe[0] <= rd_vld_q ? ram_rdata : '0;
      for (int unsigned i = 1; i < PIPE_D; i++) q_pipe[i] <= q_pipe[i-1];
    end
  end

  assign qdr_q = q_pipe[PIPE_D-1];

  qdr_resp_ram #(
    .AW(ADDR_WIDTH + 1)
  ) u_ram (
    .clk  (qdr_clk),
    .we   (ram_we),
    .waddr(ram_addr),
    .wdata(qdr_d),
    .re   (ram_re),
    .raddr(ram_addr),
    .rdata(ram_rdata)
  );
endmodule
